satd_datapath: RTL

SATD_DATAPATH -- requirements
Module: satd_datapath

---
 rtl/satd_pkg.sv | 27 ++
 rtl/hadamard4.sv | 34 +++
 rtl/satd_datapath.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/satd_pkg.sv
// Shared definitions for the SATD control unit and datapath: phase encodings,
// control-word bit positions and default widths.
package satd_pkg;

    localparam int unsigned DIFF_W_DEF = 9;
    localparam int unsigned ACC_W_DEF  = 17;

    localparam int unsigned CTRL_W    = 10;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned COUNT_W   = 3;
    localparam int unsigned SATD_W    = 16;
    localparam int unsigned MAX_COUNT = 3;

    localparam int unsigned CTRL_ROW_LOAD   = 0;
    localparam int unsigned CTRL_V_ENABLE   = 1;
    localparam int unsigned CTRL_ACC_CLEAR  = 2;
    localparam int unsigned CTRL_ACC_ENABLE = 3;
    localparam int unsigned CTRL_OUT_STROBE = 4;

    typedef enum logic [STATE_W-1:0] {
        PH_IDLE      = 2'b00,
        PH_LOAD      = 2'b01,
        PH_TRANSFORM = 2'b10,
        PH_OUTPUT    = 2'b11
    } phase_e;

endpackage

// File: rtl/hadamard4.sv
// Combinational 4-point Hadamard butterfly; output elements are 2 bits wider
// than the inputs, element 0 in the LSBs on both sides.
module hadamard4 #(
    parameter int unsigned IN_W = 9
) (
    input  logic [4*IN_W-1:0]     i_x,
    output logic [4*(IN_W+2)-1:0] o_y
);

    localparam int unsigned OUT_W = IN_W + 2;

    logic signed [OUT_W-1:0] w_a;
    logic signed [OUT_W-1:0] w_b;
    logic signed [OUT_W-1:0] w_c;
    logic signed [OUT_W-1:0] w_d;
    logic signed [OUT_W-1:0] w_s0;
    logic signed [OUT_W-1:0] w_d0;
    logic signed [OUT_W-1:0] w_s1;
    logic signed [OUT_W-1:0] w_d1;

    assign w_a = OUT_W'(signed'(i_x[IN_W-1:0]));
    assign w_b = OUT_W'(signed'(i_x[2*IN_W-1:IN_W]));
    assign w_c = OUT_W'(signed'(i_x[3*IN_W-1:2*IN_W]));
    assign w_d = OUT_W'(signed'(i_x[4*IN_W-1:3*IN_W]));

    assign w_s0 = w_a + w_b;
    assign w_d0 = w_a - w_b;
    assign w_s1 = w_c + w_d;
    assign w_d1 = w_c - w_d;

    // {a-b-c+d, a+b-c-d, a-b+c-d, a+b+c+d}
    assign o_y = {w_d0 - w_d1, w_s0 - w_s1, w_d0 + w_d1, w_s0 + w_s1};

endmodule

// File: rtl/satd_datapath.sv
// SATD datapath: row Hadamard into a 4x4 buffer, column Hadamard with
// absolute-sum, saturating accumulator and halved/clamped SATD output.
module satd_datapath
    import satd_pkg::*;
#(
    parameter int unsigned DIFF_W = DIFF_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_W-1:0]     ctrl_signal,
    input  logic [STATE_W-1:0]    ctrl_state,
    input  logic [COUNT_W-1:0]    ctrl_count,
    input  logic [4*DIFF_W-1:0]   diff_row,
    output logic [SATD_W-1:0]     satd,
    output logic                  satd_valid,
    output logic                  seq_error
);

    localparam int unsigned BUF_W  = DIFF_W + 2;
    localparam int unsigned COL_W  = DIFF_W + 4;
    localparam int unsigned CS_W   = COL_W + 2;
    localparam int unsigned SUM_W  = ((CS_W > ACC_W) ? CS_W : ACC_W) + 1;
    localparam int unsigned HALF_W = (ACC_W > SATD_W) ? ACC_W : SATD_W;
    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
    localparam logic [SATD_W-1:0] SATD_MAX = '1;

    logic signed [BUF_W-1:0] r_buf [4][4];
    logic [CS_W-1:0]         r_col_sum;
    logic [ACC_W-1:0]        r_acc;
    logic [SATD_W-1:0]       r_satd;
    logic                    r_satd_valid;
    logic                    r_seq_error;

    logic w_row_load;
    logic w_v_enable;
    logic w_acc_clear;
    logic w_acc_enable;
    logic w_out_strobe;
    logic w_in_idle;
    logic w_in_load;
    logic w_in_xform;
    logic w_in_out;
    logic w_cnt_ok;
    logic w_do_load;
    logic w_do_col;
    logic w_do_out;
    logic w_acc_add;
    logic w_viol;
    logic [1:0] w_idx;
    logic w_unused_rsvd;

    assign w_row_load   = ctrl_signal[CTRL_ROW_LOAD];
    assign w_v_enable   = ctrl_signal[CTRL_V_ENABLE];
    assign w_acc_clear  = ctrl_signal[CTRL_ACC_CLEAR];
    assign w_acc_enable = ctrl_signal[CTRL_ACC_ENABLE];
    assign w_out_strobe = ctrl_signal[CTRL_OUT_STROBE];
    assign w_unused_rsvd = &{1'b0, ctrl_signal[CTRL_W-1:CTRL_OUT_STROBE+1]};

    assign w_in_idle  = (ctrl_state == STATE_W'(PH_IDLE));
    assign w_in_load  = (ctrl_state == STATE_W'(PH_LOAD));
    assign w_in_xform = (ctrl_state == STATE_W'(PH_TRANSFORM));
    assign w_in_out   = (ctrl_state == STATE_W'(PH_OUTPUT));
    assign w_cnt_ok   = (ctrl_count <= COUNT_W'(MAX_COUNT));
    assign w_idx      = ctrl_count[1:0];

    // Illegal operations flag an error and are suppressed.
    assign w_do_load = w_row_load & w_in_load & w_cnt_ok;
    assign w_do_col  = w_v_enable & w_in_xform & w_cnt_ok;
    assign w_do_out  = w_out_strobe & w_in_out;
    assign w_acc_add = w_acc_enable & ~w_in_idle;
    assign w_viol    = (w_row_load & ~w_do_load) | (w_v_enable & ~w_do_col)
                     | (w_out_strobe & ~w_do_out);

    logic [4*BUF_W-1:0] w_row_h;
    logic [4*BUF_W-1:0] w_col_in;
    logic [4*COL_W-1:0] w_col_h;

    hadamard4 #(.IN_W(DIFF_W)) u_row_h4 (
        .i_x (diff_row),
        .o_y (w_row_h)
    );

    assign w_col_in = {r_buf[3][w_idx], r_buf[2][w_idx], r_buf[1][w_idx], r_buf[0][w_idx]};

    hadamard4 #(.IN_W(BUF_W)) u_col_h4 (
        .i_x (w_col_in),
        .o_y (w_col_h)
    );

    logic signed [COL_W-1:0] w_coef [4];
    logic [COL_W-1:0]        w_mag  [4];
    logic [CS_W-1:0]         w_col_sum;

    // Most-negative coefficient negates to itself, which reads correctly as unsigned.
    for (genvar k = 0; k < 4; k++) begin : g_abs
        assign w_coef[k] = w_col_h[k*COL_W +: COL_W];
        assign w_mag[k]  = w_coef[k][COL_W-1] ? COL_W'(-w_coef[k]) : COL_W'(w_coef[k]);
    end

    assign w_col_sum = CS_W'(w_mag[0]) + CS_W'(w_mag[1]) + CS_W'(w_mag[2]) + CS_W'(w_mag[3]);

    logic [ACC_W-1:0]  w_acc_base;
    logic [SUM_W-1:0]  w_acc_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic [HALF_W-1:0] w_half;
    logic [SATD_W-1:0] w_satd_next;

    // Clear takes effect before the add; the sum saturates instead of wrapping.
    always_comb begin
        w_acc_base = w_acc_clear ? '0 : r_acc;
        w_acc_sum  = SUM_W'(w_acc_base) + SUM_W'(r_col_sum);
        w_acc_next = w_acc_base;
        if (w_acc_add) begin
            if (w_acc_sum > SUM_W'(ACC_MAX)) begin
                w_acc_next = ACC_MAX;
            end else begin
                w_acc_next = ACC_W'(w_acc_sum);
            end
        end
    end

    assign w_half      = HALF_W'(r_acc >> 1);
    assign w_satd_next = (w_half > HALF_W'(SATD_MAX)) ? SATD_MAX : SATD_W'(w_half);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
            r_col_sum    <= '0;
            r_acc        <= '0;
            r_satd       <= '0;
            r_satd_valid <= 1'b0;
            r_seq_error  <= 1'b0;
        end else begin
            if (w_do_load) begin
                for (int k = 0; k < 4; k++) begin
                    r_buf[w_idx][k] <= w_row_h[k*BUF_W +: BUF_W];
                end
            end
            if (w_do_col) begin
                r_col_sum <= w_col_sum;
            end
            r_acc        <= w_acc_next;
            r_satd_valid <= w_do_out;
            if (w_do_out) begin
                r_satd <= w_satd_next;
            end
            if (w_viol) begin
                r_seq_error <= 1'b1;
            end else if (w_acc_clear) begin
                r_seq_error <= 1'b0;
            end
        end
    end

    assign satd       = r_satd;
    assign satd_valid = r_satd_valid;
    assign seq_error  = r_seq_error;

endmodule
